// File: rtl/hmac_verdict_sequencer.sv
// hmac_verdict_sequencer: buffers HMAC comparison verdicts in an in-order FIFO and
// issues one verdict per packet to the checker stage. A packet that waits too long
// with no verdict available receives a forced "drop" verdict.
// Build option: define HMAC_SEQ_STATS_EN to implement the pass/drop/timeout counters;
// otherwise those outputs are tied to zero.
module hmac_verdict_sequencer #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       v_valid,
  output logic                       v_ready,
  input  logic                       v_result,
  output logic                       comparison_valid,
  input  logic                       comparison_ready,
  output logic                       comparison_result,
  input  logic                       pkt_valid,
  input  logic                       pkt_ready,
  input  logic                       pkt_last,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       timeout_pulse,
  output logic [CNT_W-1:0]           pass_count,
  output logic [CNT_W-1:0]           drop_count,
  output logic [CNT_W-1:0]           timeout_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [AW:0]   FullLevel = DEPTH[AW:0];
  localparam logic [AW:0]   LevelOne  = 1;
  localparam logic [AW-1:0] PtrOne    = 1;
  localparam logic [TW-1:0] ToLimit   = TIMEOUT_CYCLES[TW-1:0];
  localparam logic [TW-1:0] ToOne     = 1;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StInflight = 2'd1
  } state_e;

  state_e          state_q, state_d;
  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;

  logic empty, full, push, pop, timed_out, forced, handshake;

  assign empty      = (count_q == '0);
  assign full       = (count_q == FullLevel);
  assign v_ready    = !full;
  assign push       = v_valid && v_ready;
  assign fifo_level = count_q;
  assign timed_out  = (TIMEOUT_CYCLES != 0) && (to_cnt_q == ToLimit);

  // Verdict offer, handshake detection and timeout counter next-state.
  always_comb begin
    state_d           = state_q;
    to_cnt_d          = to_cnt_q;
    comparison_valid  = 1'b0;
    comparison_result = 1'b0;
    forced            = 1'b0;
    handshake         = 1'b0;
    case (state_q)
      StIdle: begin
        // Once a forced verdict is on offer it is held until accepted so the
        // offered value never changes under the checker.
        if (timed_out) begin
          comparison_valid  = 1'b1;
          comparison_result = 1'b1;
          forced            = 1'b1;
        end else if (!empty) begin
          comparison_valid  = 1'b1;
          comparison_result = mem_q[rd_ptr_q];
        end
        handshake = comparison_valid && comparison_ready;
        if (handshake) begin
          state_d  = StInflight;
          to_cnt_d = '0;
        end else if (timed_out) begin
          to_cnt_d = to_cnt_q;
        end else if (!empty || !pkt_valid || (TIMEOUT_CYCLES == 0)) begin
          to_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + ToOne;
        end
      end
      StInflight: begin
        if (pkt_valid && pkt_ready && pkt_last) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d  = StIdle;
        to_cnt_d = '0;
      end
    endcase
  end

  assign pop           = handshake && !forced;
  assign timeout_pulse = handshake && forced;

  // State register and timeout counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // Verdict FIFO storage, pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= v_result;
        wr_ptr_q        <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + LevelOne;
        2'b01:   count_q <= count_q - LevelOne;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef HMAC_SEQ_STATS_EN
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = 1;

  logic [CNT_W-1:0] pass_q, drop_q, to_q;

  // Saturating statistics, updated on the verdict handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pass_q <= '0;
      drop_q <= '0;
      to_q   <= '0;
    end else if (handshake) begin
      if (!comparison_result && (pass_q != CntMax)) pass_q <= pass_q + CntOne;
      if (comparison_result && (drop_q != CntMax))  drop_q <= drop_q + CntOne;
      if (forced && (to_q != CntMax))               to_q   <= to_q + CntOne;
    end
  end

  assign pass_count    = pass_q;
  assign drop_count    = drop_q;
  assign timeout_count = to_q;
`else
  assign pass_count    = '0;
  assign drop_count    = '0;
  assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_hmac_verdict_sequencer.sv
// Directed self-checking bench for hmac_verdict_sequencer (DEPTH=4, TIMEOUT_CYCLES=8,
// CNT_W=4). Counter expectations follow HMAC_SEQ_STATS_EN.
module tb_hmac_verdict_sequencer;

  localparam int unsigned Depth   = 4;
  localparam int unsigned Timeout = 8;
  localparam int unsigned CntW    = 4;
  localparam int          CntMax  = (1 << CntW) - 1;
`ifdef HMAC_SEQ_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   v_valid, v_ready, v_result;
  logic                   comparison_valid, comparison_ready, comparison_result;
  logic                   pkt_valid, pkt_ready, pkt_last;
  logic [$clog2(Depth):0] fifo_level;
  logic                   timeout_pulse;
  logic [CntW-1:0]        pass_count, drop_count, timeout_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_pass = 0;
  int exp_drop = 0;
  int exp_to   = 0;

  hmac_verdict_sequencer #(
    .DEPTH          (Depth),
    .TIMEOUT_CYCLES (Timeout),
    .CNT_W          (CntW)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .v_valid           (v_valid),
    .v_ready           (v_ready),
    .v_result          (v_result),
    .comparison_valid  (comparison_valid),
    .comparison_ready  (comparison_ready),
    .comparison_result (comparison_result),
    .pkt_valid         (pkt_valid),
    .pkt_ready         (pkt_ready),
    .pkt_last          (pkt_last),
    .fifo_level        (fifo_level),
    .timeout_pulse     (timeout_pulse),
    .pass_count        (pass_count),
    .drop_count        (drop_count),
    .timeout_count     (timeout_count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clock);
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CntMax) ? CntMax : v + 1;
  endfunction

  task automatic push_verdict(input bit r);
    v_valid  = 1'b1;
    v_result = r;
    tick();
    v_valid  = 1'b0;
    v_result = 1'b0;
  endtask

  task automatic take_verdict(input bit r, input bit forced, input string tag);
    check_eq({tag, "_valid"}, 32'(comparison_valid), 32'd1);
    check_eq({tag, "_result"}, 32'(comparison_result), 32'(r));
    comparison_ready = 1'b1;
    #1;
    check_eq({tag, "_pulse"}, 32'(timeout_pulse), 32'(forced));
    tick();
    comparison_ready = 1'b0;
    if (forced) exp_to = sat_inc(exp_to);
    if (r) exp_drop = sat_inc(exp_drop);
    else   exp_pass = sat_inc(exp_pass);
  endtask

  task automatic send_packet(input int beats);
    for (int i = 0; i < beats; i++) begin
      pkt_valid = 1'b1;
      pkt_ready = 1'b1;
      pkt_last  = (i == beats - 1);
      tick();
    end
    pkt_valid = 1'b0;
    pkt_ready = 1'b0;
    pkt_last  = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    check_eq({tag, "_pass_count"}, 32'(pass_count), StatsEn ? 32'(exp_pass) : 32'd0);
    check_eq({tag, "_drop_count"}, 32'(drop_count), StatsEn ? 32'(exp_drop) : 32'd0);
    check_eq({tag, "_timeout_count"}, 32'(timeout_count), StatsEn ? 32'(exp_to) : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    v_valid = 1'b0; v_result = 1'b0; comparison_ready = 1'b0;
    pkt_valid = 1'b0; pkt_ready = 1'b0; pkt_last = 1'b0;
    tick();
    tick();
    check_eq("rst_comparison_valid", 32'(comparison_valid), 32'd0);
    check_eq("rst_comparison_result", 32'(comparison_result), 32'd0);
    check_eq("rst_fifo_level", 32'(fifo_level), 32'd0);
    check_eq("rst_timeout_pulse", 32'(timeout_pulse), 32'd0);
    check_counters("rst");
    reset = 1'b0;
    tick();
    check_eq("rst_v_ready", 32'(v_ready), 32'd1);

    // Single pass verdict, 3-beat packet; a second verdict arrives mid-packet
    // and must stay hidden until the last beat has transferred.
    check_eq("t1_valid_before_push", 32'(comparison_valid), 32'd0);
    push_verdict(1'b0);
    take_verdict(1'b0, 1'b0, "t1");
    pkt_valid = 1'b1; pkt_ready = 1'b1; pkt_last = 1'b0;
    v_valid = 1'b1; v_result = 1'b0;
    tick();
    v_valid = 1'b0;
    check_eq("t1_inflight_beat1", 32'(comparison_valid), 32'd0);
    check_eq("t1_level_inflight", 32'(fifo_level), 32'd1);
    tick();
    check_eq("t1_inflight_beat2", 32'(comparison_valid), 32'd0);
    pkt_last = 1'b1;
    tick();
    pkt_valid = 1'b0; pkt_ready = 1'b0; pkt_last = 1'b0;
    take_verdict(1'b0, 1'b0, "t1_second");
    send_packet(1);
    check_counters("t1");

    // Fill the FIFO, refuse a 5th push, then drain in order.
    push_verdict(1'b1);
    push_verdict(1'b0);
    push_verdict(1'b1);
    push_verdict(1'b1);
    check_eq("t2_level_full", 32'(fifo_level), 32'd4);
    check_eq("t2_v_ready_full", 32'(v_ready), 32'd0);
    push_verdict(1'b0);
    check_eq("t2_level_after_5th", 32'(fifo_level), 32'd4);
    take_verdict(1'b1, 1'b0, "t2_v0");
    check_eq("t2_level_3", 32'(fifo_level), 32'd3);
    send_packet(2);
    take_verdict(1'b0, 1'b0, "t2_v1");
    send_packet(1);
    take_verdict(1'b1, 1'b0, "t2_v2");
    send_packet(1);
    take_verdict(1'b1, 1'b0, "t2_v3");
    send_packet(1);
    check_eq("t2_level_empty", 32'(fifo_level), 32'd0);
    check_counters("t2");

    // Empty FIFO with a waiting packet: forced drop after exactly 8 cycles.
    pkt_valid = 1'b1; pkt_ready = 1'b0; pkt_last = 1'b0;
    repeat (Timeout - 1) tick();
    check_eq("t3_valid_before_timeout", 32'(comparison_valid), 32'd0);
    tick();
    check_eq("t3_level", 32'(fifo_level), 32'd0);
    take_verdict(1'b1, 1'b1, "t3_forced");
    check_eq("t3_pulse_one_cycle", 32'(timeout_pulse), 32'd0);
    send_packet(1);
    check_counters("t3");

    // A verdict arriving during the wait wins over the timeout.
    pkt_valid = 1'b1; pkt_ready = 1'b0; pkt_last = 1'b0;
    repeat (5) tick();
    push_verdict(1'b0);
    take_verdict(1'b0, 1'b0, "t4_fifo");
    send_packet(1);
    check_counters("t4");

    // Push and pop in the same cycle at level 2.
    push_verdict(1'b1);
    push_verdict(1'b0);
    check_eq("t6_level_2", 32'(fifo_level), 32'd2);
    v_valid = 1'b1; v_result = 1'b1;
    take_verdict(1'b1, 1'b0, "t6_pushpop");
    v_valid = 1'b0; v_result = 1'b0;
    check_eq("t6_level_still_2", 32'(fifo_level), 32'd2);

    // Asynchronous reset mid-packet with two verdicts buffered.
    pkt_valid = 1'b1; pkt_ready = 1'b1; pkt_last = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    check_eq("t5_async_valid", 32'(comparison_valid), 32'd0);
    check_eq("t5_async_level", 32'(fifo_level), 32'd0);
    exp_pass = 0; exp_drop = 0; exp_to = 0;
    check_counters("t5_async");
    tick();
    reset = 1'b0;
    pkt_valid = 1'b0; pkt_ready = 1'b0;
    tick();
    check_eq("t5_v_ready", 32'(v_ready), 32'd1);
    check_eq("t5_valid_idle", 32'(comparison_valid), 32'd0);
    push_verdict(1'b1);
    take_verdict(1'b1, 1'b0, "t5_idle_after_reset");
    send_packet(1);

    // Saturation of the 4-bit drop counter.
    for (int i = 0; i < 16; i++) begin
      push_verdict(1'b1);
      take_verdict(1'b1, 1'b0, "t7_drop");
      send_packet(1);
    end
    check_counters("t7_sat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
